// File: rtl/boot_monitor_pkg.sv
// -----------------------------------------------------------------------------
// boot_monitor_pkg
// Shared constants for the boot monitor: the command and reply byte codes
// exchanged over the UART, and the FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package boot_monitor_pkg;

  // Command bytes received from the host
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_GO    = 8'h47;  // 'G'
  localparam logic [7:0] CMD_HALT  = 8'h48;  // 'H'

  // Reply bytes sent back to the host
  localparam logic [7:0] RPL_WRITE   = 8'h77;  // 'w'
  localparam logic [7:0] RPL_GO      = 8'h67;  // 'g'
  localparam logic [7:0] RPL_HALT    = 8'h68;  // 'h'
  localparam logic [7:0] RPL_UNKNOWN = 8'h3F;  // '?'
  localparam logic [7:0] RPL_BUSY    = 8'h21;  // '!'

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR_HI   = 4'd1,
    ADDR_LO   = 4'd2,
    LEN       = 4'd3,
    WDATA     = 4'd4,
    RD_ADDR   = 4'd5,
    RD_WAIT1  = 4'd6,
    RD_WAIT2  = 4'd7,
    RD_SEND   = 4'd8,
    GO_RST    = 4'd9,
    HALT_WAIT = 4'd10,
    REPLY     = 4'd11
  } state_t;

  // Commands that need memory ownership and carry an address
  function automatic logic is_mem_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ) || (b == CMD_GO);
  endfunction

endpackage

// File: rtl/boot_monitor_tx_sender.sv
// -----------------------------------------------------------------------------
// tx_sender
// Hands one byte to the UART transmitter. While a request is held, the
// strobe fires in the first cycle the transmitter is idle; the strobe is
// combinational so it can never coincide with i_tx_busy=1.
// Ports:
//   i_clk       system clock
//   i_reset     synchronous active-low reset
//   i_req       send request (level, held until o_tx_start)
//   i_byte      byte to send
//   i_tx_busy   transmitter busy
//   o_tx_data   byte to transmitter (holds last sent byte)
//   o_tx_start  one-cycle send strobe
// -----------------------------------------------------------------------------
module tx_sender (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic [7:0] i_byte,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start
);

  logic       w_fire;
  logic [7:0] r_last;

  // Reset gates the strobe so a command being aborted cannot slip out a
  // byte in the very cycle reset is applied.
  assign w_fire = i_req & ~i_tx_busy & i_reset;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_last <= '0;
    end else if (w_fire) begin
      r_last <= i_byte;
    end
  end

  assign o_tx_start = w_fire;
  assign o_tx_data  = w_fire ? i_byte : r_last;

endmodule

// File: rtl/boot_monitor.sv
// -----------------------------------------------------------------------------
// boot_monitor
// UART-driven boot monitor. Parses host commands to write/read the shared
// program memory, start the cpu at an address, or halt it and reclaim memory.
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   rx_data/rx_valid        bytes from the UART receiver
//   tx_data/tx_start/tx_busy bytes to the UART transmitter
//   mem_raddr/mem_data_out  memory read port (2-cycle read latency)
//   mem_waddr/mem_data_in/mem_write  memory write port
//   mem_owner               0 = monitor owns memory, 1 = cpu owns memory
//   cpu_reset/cpu_halt/cpu_halted    cpu control
//   start_address           cpu start address
// -----------------------------------------------------------------------------
module boot_monitor
  import boot_monitor_pkg::*;
#(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [addr_width-1:0] mem_raddr,
  input  logic [7:0]            mem_data_out,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  output logic                  mem_owner,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic [addr_width-1:0] start_address
);

  localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [7:0]            r_cmd;
  logic [7:0]            r_addr_hi;
  logic [addr_width-1:0] r_addr;
  logic [8:0]            r_count;
  logic [7:0]            r_reply;
  logic                  r_go_cnt;
  logic [addr_width-1:0] r_mem_raddr;
  logic [addr_width-1:0] r_mem_waddr;
  logic [7:0]            r_mem_data_in;
  logic                  r_mem_write;
  logic                  r_mem_owner;
  logic                  r_cpu_reset;
  logic                  r_cpu_halt;
  logic [addr_width-1:0] r_start_address;
  logic                  w_tx_req;
  logic [7:0]            w_tx_byte;
  logic                  w_tx_start;

  tx_sender u_tx_sender (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_req      (w_tx_req),
    .i_byte     (w_tx_byte),
    .i_tx_busy  (tx_busy),
    .o_tx_data  (tx_data),
    .o_tx_start (w_tx_start)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bytes arriving in states that do not consume rx simply fall through
  // here unused, which is how they get dropped.
  always_comb begin
    w_next_state = r_state;
    w_tx_req     = 1'b0;
    w_tx_byte    = r_reply;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (is_mem_cmd(rx_data)) begin
            w_next_state = r_mem_owner ? REPLY : ADDR_HI;
          end else if (rx_data == CMD_HALT) begin
            w_next_state = r_mem_owner ? HALT_WAIT : REPLY;
          end else begin
            w_next_state = REPLY;
          end
        end
      end
      ADDR_HI: if (rx_valid) w_next_state = ADDR_LO;
      ADDR_LO: if (rx_valid) w_next_state = (r_cmd == CMD_GO) ? GO_RST : LEN;
      LEN:     if (rx_valid) w_next_state = (r_cmd == CMD_WRITE) ? WDATA : RD_ADDR;
      WDATA:   if (rx_valid && r_count == 9'd1) w_next_state = REPLY;
      RD_ADDR:  w_next_state = RD_WAIT1;
      RD_WAIT1: w_next_state = RD_WAIT2;
      RD_WAIT2: w_next_state = RD_SEND;
      RD_SEND: begin
        w_tx_req  = 1'b1;
        w_tx_byte = mem_data_out;
        if (w_tx_start) w_next_state = (r_count == 9'd1) ? IDLE : RD_ADDR;
      end
      GO_RST:    if (r_go_cnt) w_next_state = REPLY;
      HALT_WAIT: if (cpu_halted) w_next_state = REPLY;
      REPLY: begin
        w_tx_req = 1'b1;
        if (w_tx_start) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: captures command fields, drives the memory ports and cpu
  // control. The read address is held through RD_SEND so that the memory
  // output stays valid however long the transmitter keeps us waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cmd           <= '0;
      r_addr_hi       <= '0;
      r_addr          <= '0;
      r_count         <= '0;
      r_reply         <= '0;
      r_go_cnt        <= 1'b0;
      r_mem_raddr     <= '0;
      r_mem_waddr     <= '0;
      r_mem_data_in   <= '0;
      r_mem_write     <= 1'b0;
      r_mem_owner     <= 1'b0;
      r_cpu_reset     <= 1'b1;
      r_cpu_halt      <= 1'b0;
      r_start_address <= '0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_valid) begin
            r_cmd <= rx_data;
            if (is_mem_cmd(rx_data)) begin
              r_reply <= RPL_BUSY;
            end else if (rx_data == CMD_HALT) begin
              r_reply <= RPL_HALT;
              if (r_mem_owner) r_cpu_halt <= 1'b1;
            end else begin
              r_reply <= RPL_UNKNOWN;
            end
          end
        end
        ADDR_HI: if (rx_valid) r_addr_hi <= rx_data;
        ADDR_LO: begin
          if (rx_valid) begin
            r_addr   <= addr_width'({r_addr_hi, rx_data});
            r_go_cnt <= 1'b0;
            if (r_cmd == CMD_GO) r_start_address <= addr_width'({r_addr_hi, rx_data});
          end
        end
        LEN: if (rx_valid) r_count <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        WDATA: begin
          if (rx_valid) begin
            r_mem_write   <= 1'b1;
            r_mem_waddr   <= r_addr;
            r_mem_data_in <= rx_data;
            r_addr        <= r_addr + ADDR_ONE;
            r_count       <= r_count - 9'd1;
            r_reply       <= RPL_WRITE;
          end
        end
        RD_ADDR: r_mem_raddr <= r_addr;
        RD_SEND: begin
          if (w_tx_start) begin
            r_addr  <= r_addr + ADDR_ONE;
            r_count <= r_count - 9'd1;
          end
        end
        GO_RST: begin
          // cpu_reset is held for both GO_RST cycles, then released in the
          // same edge that hands memory to the cpu.
          r_cpu_reset <= 1'b1;
          r_go_cnt    <= 1'b1;
          if (r_go_cnt) begin
            r_cpu_reset <= 1'b0;
            r_mem_owner <= 1'b1;
            r_reply     <= RPL_GO;
          end
        end
        HALT_WAIT: begin
          if (cpu_halted) begin
            r_cpu_halt  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_mem_owner <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_start      = w_tx_start;
  assign mem_raddr     = r_mem_raddr;
  assign mem_waddr     = r_mem_waddr;
  assign mem_data_in   = r_mem_data_in;
  assign mem_write     = r_mem_write & ~r_mem_owner;
  assign mem_owner     = r_mem_owner;
  assign cpu_reset     = r_cpu_reset;
  assign cpu_halt      = r_cpu_halt;
  assign start_address = r_start_address;

endmodule

// File: tb/tb_boot_monitor.sv
// -----------------------------------------------------------------------------
// tb_boot_monitor
// Directed bench for boot_monitor: a 2-cycle-latency memory model, a UART
// transmitter model that stays busy for several cycles per byte, and a
// linear sequence of host commands with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_boot_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [8:0] mem_raddr;
  logic [7:0] memDataOut;
  logic [8:0] mem_waddr;
  logic [7:0] mem_data_in;
  logic       mem_write;
  logic       mem_owner;
  logic       cpu_reset;
  logic       cpu_halt;
  logic       cpu_halted;
  logic [8:0] start_address;

  logic [7:0] memArray [0:511];
  logic [7:0] memPipe;
  logic [7:0] txQueue [$];
  int         busyCnt = 0;
  int         writeCount = 0;
  int         txBusyViolations = 0;
  int         ownerViolations = 0;
  int         assertCount = 0;
  int         failCount = 0;
  int         wrBase;
  int         haltCycles;

  always #5 clk = ~clk;

  boot_monitor #(.addr_width(9)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .mem_raddr     (mem_raddr),
    .mem_data_out  (memDataOut),
    .mem_waddr     (mem_waddr),
    .mem_data_in   (mem_data_in),
    .mem_write     (mem_write),
    .mem_owner     (mem_owner),
    .cpu_reset     (cpu_reset),
    .cpu_halt      (cpu_halt),
    .cpu_halted    (cpu_halted),
    .start_address (start_address)
  );

  assign tx_busy = (busyCnt != 0);

  // Memory with two register stages on the read path, plus a UART model
  // that collects sent bytes and stays busy for six cycles after each one.
  always @(posedge clk) begin
    if (mem_write) begin
      memArray[mem_waddr] <= mem_data_in;
      writeCount <= writeCount + 1;
      if (mem_owner) ownerViolations <= ownerViolations + 1;
    end
    memPipe    <= memArray[mem_raddr];
    memDataOut <= memPipe;
    if (tx_start) begin
      txQueue.push_back(tx_data);
      if (tx_busy) txBusyViolations <= txBusyViolations + 1;
      busyCnt <= 6;
    end else if (busyCnt != 0) begin
      busyCnt <= busyCnt - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One rx byte: strobe for one cycle, returns on the negedge after the
  // DUT has sampled it.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expectTx(input string tag, input logic [7:0] expected);
    int waited = 0;
    while (txQueue.size() == 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_seen"}, (txQueue.size() != 0), 1);
    if (txQueue.size() != 0) checkOutput(tag, txQueue.pop_front(), expected);
  endtask

  task automatic checkResetState(input string prefix);
    checkOutput({prefix, "_cpu_reset"}, cpu_reset, 1);
    checkOutput({prefix, "_cpu_halt"}, cpu_halt, 0);
    checkOutput({prefix, "_mem_owner"}, mem_owner, 0);
    checkOutput({prefix, "_mem_write"}, mem_write, 0);
    checkOutput({prefix, "_tx_start"}, tx_start, 0);
    checkOutput({prefix, "_start_address"}, start_address, 0);
    checkOutput({prefix, "_tx_data"}, tx_data, 0);
    checkOutput({prefix, "_mem_raddr"}, mem_raddr, 0);
    checkOutput({prefix, "_mem_waddr"}, mem_waddr, 0);
    checkOutput({prefix, "_mem_data_in"}, mem_data_in, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset      = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    cpu_halted = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b1;
    @(negedge clk);

    // 'W' 00 10 03 AA BB CC
    applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h03);
    wrBase = writeCount;
    applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC);
    expectTx("write_reply", 8'h77);
    checkOutput("write_count", writeCount - wrBase, 3);
    checkOutput("mem_010", memArray[9'h010], 8'hAA);
    checkOutput("mem_011", memArray[9'h011], 8'hBB);
    checkOutput("mem_012", memArray[9'h012], 8'hCC);

    // 'R' 00 10 03 -> AA BB CC, no trailing reply
    applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h03);
    expectTx("read0", 8'hAA);
    expectTx("read1", 8'hBB);
    expectTx("read2", 8'hCC);
    repeat (40) @(negedge clk);
    checkOutput("read_no_trailing", txQueue.size(), 0);

    // 'W' 01 00 00 -> 256 bytes at 0x100..0x1FF
    applyStimulus(8'h57); applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h00);
    wrBase = writeCount;
    for (int i = 0; i < 256; i++) applyStimulus(8'(i) ^ 8'h5A);
    expectTx("write256_reply", 8'h77);
    checkOutput("write256_count", writeCount - wrBase, 256);
    checkOutput("mem_100", memArray[9'h100], 8'h5A);
    checkOutput("mem_180", memArray[9'h180], 8'hDA);
    checkOutput("mem_1ff", memArray[9'h1FF], 8'hA5);
    repeat (10) @(negedge clk);
    checkOutput("write256_single_reply", txQueue.size(), 0);

    // 'W' 01 FF 02 11 22 -> address wraps to 0x000
    applyStimulus(8'h57); applyStimulus(8'h01); applyStimulus(8'hFF); applyStimulus(8'h02);
    applyStimulus(8'h11); applyStimulus(8'h22);
    expectTx("wrap_reply", 8'h77);
    checkOutput("mem_1ff_wrap", memArray[9'h1FF], 8'h11);
    checkOutput("mem_000_wrap", memArray[9'h000], 8'h22);

    // unknown byte, and 'H' while monitor already owns memory
    applyStimulus(8'h5A);
    expectTx("unknown_reply", 8'h3F);
    applyStimulus(8'h48);
    expectTx("halt_idle_reply", 8'h68);
    checkOutput("halt_idle_cpu_halt", cpu_halt, 0);

    // 'G' 00 20
    applyStimulus(8'h47); applyStimulus(8'h00); applyStimulus(8'h20);
    checkOutput("go_start_address", start_address, 9'h020);
    checkOutput("go_rst_c1_reset", cpu_reset, 1);
    checkOutput("go_rst_c1_owner", mem_owner, 0);
    @(negedge clk);
    checkOutput("go_rst_c2_reset", cpu_reset, 1);
    checkOutput("go_rst_c2_owner", mem_owner, 0);
    @(negedge clk);
    checkOutput("go_run_reset", cpu_reset, 0);
    checkOutput("go_run_owner", mem_owner, 1);
    expectTx("go_reply", 8'h67);

    // 'W' while cpu owns memory -> '!' and no write
    wrBase = writeCount;
    applyStimulus(8'h57);
    expectTx("busy_reply", 8'h21);
    checkOutput("busy_no_write", writeCount - wrBase, 0);
    checkOutput("busy_owner_kept", mem_owner, 1);

    // 'H' while running, cpu_halted raised after 5 cycles
    applyStimulus(8'h48);
    haltCycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (cpu_halt) haltCycles++;
      @(negedge clk);
    end
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
    checkOutput("halt_cycles", haltCycles, 5);
    checkOutput("halt_done_halt", cpu_halt, 0);
    checkOutput("halt_done_owner", mem_owner, 0);
    checkOutput("halt_done_reset", cpu_reset, 1);
    expectTx("halt_reply", 8'h68);

    // reset during WDATA after 1 of 3 bytes
    applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h30); applyStimulus(8'h03);
    wrBase = writeCount;
    applyStimulus(8'hAA);
    reset = 1'b0;
    @(negedge clk);
    checkResetState("midreset");
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midreset_writes", writeCount - wrBase, 1);
    checkOutput("midreset_no_tx", txQueue.size(), 0);
    applyStimulus(8'h5A);
    expectTx("midreset_unknown_reply", 8'h3F);

    checkOutput("tx_busy_violations", txBusyViolations, 0);
    checkOutput("owner_write_violations", ownerViolations, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
